// File: rtl/line_raster_engine_pkg.sv
// Shared types and width helpers for the line/rectangle raster engine.
package line_raster_engine_pkg;

  // Draw command kind
  typedef enum logic {
    MODE_LINE = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

  // Engine control state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned COORD_W_DEFAULT = 11;

  // Bresenham error term needs sign plus one guard bit over the coordinate width
  function automatic int unsigned err_w(input int unsigned coord_w);
    return coord_w + 2;
  endfunction

  localparam int unsigned ERR_W_DEFAULT = err_w(COORD_W_DEFAULT);

endpackage

// File: rtl/line_raster_engine_if.sv
// Command and pixel stream bundle for line_raster_engine.
// master = command source / pixel sink, slave = the engine.
interface line_raster_engine_if #(
  parameter int unsigned COORD_W = 11
);
  import line_raster_engine_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  mode_t              cmd_mode;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_last;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_mode, x0, y0, x1, y1, pix_ready,
    input  cmd_ready, pix_valid, x, y, pix_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, x0, y0, x1, y1, pix_ready,
    output cmd_ready, pix_valid, x, y, pix_last, busy, done
  );

endinterface

// File: rtl/line_raster_engine_bresenham_stepper.sv
// Bresenham line stepper: holds error term, deltas, directions and the current point.
// load captures a new segment; step advances one pixel; at_end flags the endpoint.
module line_raster_engine_bresenham_stepper #(
  parameter int unsigned COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               at_end_o
);
  import line_raster_engine_pkg::*;

  localparam int unsigned ErrW = err_w(COORD_W);

  logic signed [ErrW-1:0] err_q, err_d;
  logic signed [ErrW-1:0] dx_q, dx_d;
  logic signed [ErrW-1:0] dy_q, dy_d;
  logic                   sx_neg_q, sx_neg_d;
  logic                   sy_neg_q, sy_neg_d;
  logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]     xe_q, xe_d, ye_q, ye_d;

  logic signed [ErrW-1:0] ddx, ddy, abs_dx, neg_ady, e2;
  logic                   step_x, step_y;

  // Segment setup on load, otherwise one Bresenham step using the pre-step err
  always_comb begin
    ddx     = $signed({2'b00, x1_i}) - $signed({2'b00, x0_i});
    ddy     = $signed({2'b00, y1_i}) - $signed({2'b00, y0_i});
    abs_dx  = (ddx < 0) ? -ddx : ddx;
    neg_ady = (ddy < 0) ? ddy : -ddy;
    e2      = err_q <<< 1;
    step_x  = (e2 >= dy_q);
    step_y  = (e2 <= dx_q);

    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;

    if (load_i) begin
      dx_d     = abs_dx;
      dy_d     = neg_ady;
      err_d    = abs_dx + neg_ady;
      sx_neg_d = (ddx < 0);
      sy_neg_d = (ddy < 0);
      x_d      = x0_i;
      y_d      = y0_i;
      xe_d     = x1_i;
      ye_d     = y1_i;
    end else if (step_i) begin
      err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
      if (step_x) x_d = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
      if (step_y) y_d = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
    end
  end

  // Stepper state register
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
    end else begin
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign at_end_o = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/line_raster_engine.sv
// Line / filled-rectangle raster engine: accepts draw commands and streams pixel
// coordinates under valid/ready backpressure, pulsing done after the last pixel.
// Optional macro LINE_RASTER_CLIP_EN: off-screen pixels are stepped silently.
module line_raster_engine #(
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input logic                 clk,
  input logic                 reset,
  line_raster_engine_if.slave bus
);
  import line_raster_engine_pkg::*;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;
  logic               done_q, done_d;

  logic               accept, in_run, advance, is_last, clipped;
  logic               line_step, fill_step;
  logic [COORD_W-1:0] line_x, line_y, cur_x, cur_y;
  logic               line_at_end;

  line_raster_engine_bresenham_stepper #(
    .COORD_W (COORD_W)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (line_step),
    .x0_i     (bus.x0),
    .y0_i     (bus.y0),
    .x1_i     (bus.x1),
    .y1_i     (bus.y1),
    .x_o      (line_x),
    .y_o      (line_y),
    .at_end_o (line_at_end)
  );

  // Current pixel selection and clip qualification
  always_comb begin
    in_run  = (state_q == RUN);
    accept  = bus.cmd_valid && (state_q == IDLE);
    cur_x   = (mode_q == MODE_FILL) ? fx_q : line_x;
    cur_y   = (mode_q == MODE_FILL) ? fy_q : line_y;
    is_last = (mode_q == MODE_FILL) ? ((fx_q == xmax_q) && (fy_q == ymax_q)) : line_at_end;
`ifdef LINE_RASTER_CLIP_EN
    clipped = (32'(cur_x) >= SCREEN_W) || (32'(cur_y) >= SCREEN_H);
`else
    clipped = 1'b0;
`endif
    // Clipped pixels advance on their own, visible ones wait for the sink
    advance = in_run && (clipped || bus.pix_ready);
  end

  // FSM next state, done pulse and stepper/scan advance requests
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    line_step = 1'b0;
    fill_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (advance) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (mode_q == MODE_FILL) begin
            fill_step = 1'b1;
          end else begin
            line_step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture and row-major rectangle scan
  always_comb begin
    mode_d = mode_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    fx_d   = fx_q;
    fy_d   = fy_q;
    if (accept) begin
      mode_d = bus.cmd_mode;
      xmin_d = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
      xmax_d = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
      ymin_d = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
      ymax_d = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
      fx_d   = xmin_d;
      fy_d   = ymin_d;
    end else if (fill_step) begin
      if (fx_q == xmax_q) begin
        fx_d = xmin_q;
        fy_d = fy_q + 1'b1;
      end else begin
        fx_d = fx_q + 1'b1;
      end
    end
  end

  // Control and scan registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_LINE;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are pure functions of registered state, so they hold under backpressure
  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.busy      = in_run;
    bus.done      = done_q;
    bus.pix_valid = in_run && !clipped;
    bus.pix_last  = in_run && !clipped && is_last;
    bus.x         = in_run ? cur_x : '0;
    bus.y         = in_run ? cur_y : '0;
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed self-checking bench for line_raster_engine.
module tb_line_raster_engine;
  import line_raster_engine_pkg::*;

  localparam int unsigned CW = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  line_raster_engine_if #(.COORD_W(CW)) bus ();

  line_raster_engine #(
    .COORD_W  (CW),
    .SCREEN_W (640),
    .SCREEN_H (480)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  int   got_x [64];
  int   got_y [64];
  logic got_last [64];
  int   n_got, done_cyc, last_cyc, n_done;
  int   exp_x [16];
  int   exp_y [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_exp(input int i, input int ex, input int ey);
    exp_x[i] = ex;
    exp_y[i] = ey;
  endtask

  task automatic send(input mode_t m, input int ax, input int ay, input int bx, input int by);
    @(negedge clk);
    bus.cmd_mode  = m;
    bus.x0        = CW'(ax);
    bus.y0        = CW'(ay);
    bus.x1        = CW'(bx);
    bus.y1        = CW'(by);
    bus.cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    // Scramble operands to show they were captured at accept
    bus.x0 = '1;
    bus.y0 = '1;
    bus.x1 = '0;
    bus.y1 = '0;
  endtask

  // Collect pixels until done, driving pix_ready from a 4-cycle pattern
  task automatic collect(input logic [3:0] pat, input int budget);
    logic pend;
    int   hx, hy;
    logic hl;
    pend = 1'b0;
    hx = 0; hy = 0; hl = 1'b0;
    n_got = 0; done_cyc = -1; last_cyc = -1; n_done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.pix_ready = pat[c % 4];
      #1;
      if (c == 0) check("first_valid", 32'(bus.pix_valid), 1);
      if (pend) begin
        check("hold_valid", 32'(bus.pix_valid), 1);
        check("hold_x", 32'(bus.x), 32'(hx));
        check("hold_y", 32'(bus.y), 32'(hy));
        check("hold_last", 32'(bus.pix_last), 32'(hl));
        pend = 1'b0;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = c;
        check("done_cmd_ready", 32'(bus.cmd_ready), 1);
        check("done_not_busy", 32'(bus.busy), 0);
        break;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (n_got < 64) begin
          got_x[n_got]    = int'(bus.x);
          got_y[n_got]    = int'(bus.y);
          got_last[n_got] = bus.pix_last;
        end
        n_got++;
        if (bus.pix_last) last_cyc = c;
      end else if (bus.pix_valid) begin
        pend = 1'b1;
        hx = int'(bus.x);
        hy = int'(bus.y);
        hl = bus.pix_last;
      end
    end
    bus.pix_ready = 1'b0;
    if (done_cyc < 0) check("done_seen", 0, 1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
  endtask

  task automatic verify(input string tag, input int n);
    check($sformatf("%s_count", tag), 32'(n_got), 32'(n));
    for (int i = 0; i < n && i < n_got; i++) begin
      check($sformatf("%s_x%0d", tag, i), 32'(got_x[i]), 32'(exp_x[i]));
      check($sformatf("%s_y%0d", tag, i), 32'(got_y[i]), 32'(exp_y[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == n - 1));
    end
    check($sformatf("%s_done_lat", tag), 32'(done_cyc), 32'(last_cyc + 1));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = MODE_LINE;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_pix_valid", 32'(bus.pix_valid), 0);
    check("rst_pix_last", 32'(bus.pix_last), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_x", 32'(bus.x), 0);
    check("rst_y", 32'(bus.y), 0);

    // 1: shallow line, sink always ready
    set_exp(0, 0, 0); set_exp(1, 1, 0); set_exp(2, 2, 1);
    set_exp(3, 3, 1); set_exp(4, 4, 2); set_exp(5, 5, 2);
    send(MODE_LINE, 0, 0, 5, 2);
    collect(4'b1111, 60);
    verify("line1", 6);

    // 2: steep line, negative x, ready toggling 1010
    set_exp(0, 5, 5); set_exp(1, 4, 6); set_exp(2, 3, 7);
    set_exp(3, 3, 8); set_exp(4, 2, 9);
    send(MODE_LINE, 5, 5, 2, 9);
    collect(4'b0101, 60);
    verify("line2", 5);

    // 3: fill with swapped corners
    set_exp(0, 1, 1); set_exp(1, 2, 1); set_exp(2, 3, 1);
    set_exp(3, 1, 2); set_exp(4, 2, 2); set_exp(5, 3, 2);
    send(MODE_FILL, 3, 2, 1, 1);
    collect(4'b1011, 60);
    verify("fill3", 6);

    // 4: degenerate line
    set_exp(0, 7, 7);
    send(MODE_LINE, 7, 7, 7, 7);
    collect(4'b1111, 20);
    verify("dot4", 1);

    // 5: reset mid-command drops it without a done pulse
    send(MODE_LINE, 0, 0, 100, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.pix_ready = 1'b1;
      #1;
      check("rst5_x", 32'(bus.x), 32'(i));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.pix_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst5_pix_valid", 32'(bus.pix_valid), 0);
      check("rst5_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rst5_done", 32'(bus.done), 0);
    end

    // Degenerate fill after reset
    set_exp(0, 9, 4);
    send(MODE_FILL, 9, 4, 9, 4);
    collect(4'b1111, 20);
    verify("dot_fill", 1);

`ifdef LINE_RASTER_CLIP_EN
    // 6: line running off the right edge
    send(MODE_LINE, 636, 0, 643, 0);
    collect(4'b1111, 40);
    check("clip_count", 32'(n_got), 4);
    check("clip_done", 32'(n_done), 1);
    for (int i = 0; i < 4 && i < n_got; i++) begin
      check($sformatf("clip_x%0d", i), 32'(got_x[i]), 32'(636 + i));
      check($sformatf("clip_last%0d", i), 32'(got_last[i]), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
